// File: rtl/sync_updown_counter.sv
// sync_updown_counter: modulo-(MAX+1) up/down counter built on a toggle chain, with clear, clamped load, terminal count and wrap pulse
// clk/rst_n: clock, async active-low reset; clr: sync clear; load/d: sync load (clamped to MAX)
// en/up: count enable and direction; q: count; tc: terminal count (comb); wrap: registered wrap pulse
module sync_updown_counter #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] MAX = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);
  logic [WIDTH-1:0] t;
  logic             wrap_ev;
  logic [WIDTH-1:0] q_nxt;
  assign t[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_t
    assign t[i] = up ? &q[i-1:0] : ~|q[i-1:0];
  end
  // >= on the up side steers out-of-range states back to 0 instead of locking up
  assign wrap_ev = up ? q >= MAX : q == '0;
  assign q_nxt   = wrap_ev ? (up ? '0 : MAX) : q ^ t;
  assign tc      = en & ((up & q == MAX) | (~up & q == '0));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q    <= '0;
      wrap <= 1'b0;
    end else if (clr) begin
      q    <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      q    <= d > MAX ? MAX : d;
      wrap <= 1'b0;
    end else begin
      q    <= en ? q_nxt : q;
      wrap <= en & wrap_ev;
    end
endmodule

// File: tb/tb_sync_updown_counter.sv
// tb_sync_updown_counter: directed checks of a decade counter and a two-digit cascade
module tb_sync_updown_counter;
  logic       clk = 1'b0;
  logic       rst_n, clr, load, en, up;
  logic [3:0] d, q, q_hi;
  logic       tc, wrap, tc_hi, wrap_hi;
  int         n_err = 0;
  int         n_chk = 0;
  int         hi_wraps;
  logic [3:0] exp_dn [4] = '{4'd1, 4'd0, 4'd9, 4'd8};
  always #5 clk = ~clk;
  sync_updown_counter #(.WIDTH(4), .MAX(4'd9)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .d(d), .en(en), .up(up),
    .q(q), .tc(tc), .wrap(wrap)
  );
  sync_updown_counter #(.WIDTH(4), .MAX(4'd9)) hi (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(1'b0), .d(4'd0), .en(tc), .up(up),
    .q(q_hi), .tc(tc_hi), .wrap(wrap_hi)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; d = '0;
    repeat (2) tick();
    check("rst_q", q, 0);
    check("rst_wrap", wrap, 0);
    rst_n = 1'b1;
    load = 1'b1; d = 4'd7;
    tick();
    check("load7", q, 7);
    load = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_q", q, 0);
    check("async_rst_wrap", wrap, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_q", q, 0);
      check("hold_tc", tc, 0);
      check("hold_wrap", wrap, 0);
    end
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("up_q", q, (i + 1) % 10);
      check("up_tc", tc, (i + 1) % 10 == 9);
      check("up_wrap", wrap, i == 9);
    end
    en = 1'b0; load = 1'b1; d = 4'd2;
    tick();
    check("load2", q, 2);
    load = 1'b0; en = 1'b1; up = 1'b0;
    #1 check("dn_tc_at2", tc, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("dn_q", q, exp_dn[i]);
      check("dn_tc", tc, exp_dn[i] == 0);
      check("dn_wrap", wrap, exp_dn[i] == 9);
    end
    en = 1'b0; load = 1'b1; d = 4'd9;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b0;
    tick();
    check("max_turn_q", q, 8);
    check("max_turn_wrap", wrap, 0);
    en = 1'b0; load = 1'b1; d = 4'd5;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b0;
    tick();
    check("dir_flip_q", q, 4);
    en = 1'b0;
    clr = 1'b1; load = 1'b1; d = 4'd6; en = 1'b1; up = 1'b1;
    tick();
    check("prio_clr_q", q, 0);
    check("prio_clr_wrap", wrap, 0);
    clr = 1'b0;
    tick();
    check("prio_load_q", q, 6);
    en = 1'b0; d = 4'd13;
    tick();
    check("clamp_q", q, 9);
    load = 1'b0; en = 1'b1; up = 1'b1;
    #1 check("clamp_tc", tc, 1);
    tick();
    check("clamp_wrap_q", q, 0);
    check("clamp_wrap", wrap, 1);
    tick();
    check("pulse_q", q, 1);
    check("pulse_wrap", wrap, 0);
    en = 1'b0; clr = 1'b1;
    tick();
    check("cas_clr_lo", q, 0);
    check("cas_clr_hi", q_hi, 0);
    clr = 1'b0; en = 1'b1; up = 1'b1; hi_wraps = 0;
    for (int n = 1; n <= 100; n++) begin
      tick();
      check("cas_val", 32'(q_hi) * 10 + 32'(q), n % 100);
      check("cas_hi_wrap", wrap_hi, n == 100);
      hi_wraps += int'(wrap_hi);
    end
    check("cas_hi_wraps", hi_wraps, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
